truth_sweep_ctrl: RTL and testbench
===================================

Name: truth_sweep_ctrl

Overview:
- Sequencer for the shared 3-input combinational evaluator, the X/Y/Z -> A gate network.
- On start, it drives all 8 input combinations in order {X,Y,Z} = 0..7 and waits a programmable settle time for each one.
- It samples A for each combination, assembles an 8-bit truth table, and compares it against an expected table.
- It replaces free-running stimulus generators with a handshake-driven, self-checking controller.

Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before the sample cycle. Legal range 1..15.
- EXPECTED, 8'h26: golden truth table; bit i is the expected A for {X,Y,Z}=i.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled only in IDLE; begins a sweep.
- abort  input  1  level; when high in any busy state, the sweep is cancelled on the next edge.
- a  input  1  evaluator output A.
- x  output  1  evaluator input X, registered.
- y  output  1  evaluator input Y, registered.
- z  output  1  evaluator input Z, registered.
- busy  output  1  high in APPLY and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches; held until the next start.
- table_out  output  8  captured truth table; bit i = A sampled for vector i.
- err_count  output  4  number of mismatching vectors, range 0..8.
- fail_idx  output  3  index of the first mismatching vector; 0 if none.

Behaviour:
- Reset (async, while rst=1): state=IDLE; x=y=z=0; busy=0; done=0; pass=0; table_out=0; err_count=0; fail_idx=0; internal idx=0; settle counter cnt=0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE -> APPLY when start=1:
  - {x,y,z}<=3'b000, idx<=0, cnt<=0.
  - table_out, err_count and fail_idx cleared; pass<=0.
- APPLY: cnt increments each cycle. When cnt==SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE (one cycle): on the closing edge:
  - table_out[idx]<=a.
  - If a!=EXPECTED[idx]: err_count<=err_count+1; fail_idx<=idx if this is the first mismatch of the sweep.
  - If idx<7: idx<=idx+1, {x,y,z}<=idx+1, cnt<=0 -> APPLY.
  - If idx==7: -> DONE.
- Per-vector timing: each vector is held SETTLE_CYCLES+1 cycles. A is sampled at the final edge of that window.
- DONE (one cycle):
  - done=1.
  - pass=1 if err_count==0 (computed including the vector-7 result), otherwise pass=0.
  - {x,y,z} returned to 000. Next state IDLE.
- Sweep latency: if start is sampled at edge 0, done is high during the cycle following edge 8*(SETTLE_CYCLES+1). With defaults, that edge is 24.
- start while busy or in DONE: ignored; no restart and no queuing.
- abort in APPLY/SAMPLE: next state IDLE; {x,y,z}<=000; no done pulse; pass stays 0. table_out and err_count keep their partial values.
- abort in IDLE or DONE: no effect; a DONE cycle still pulses done.
- start and abort both high in IDLE: start wins; abort is evaluated from APPLY onward, so the sweep cancels one cycle later.
- rst asserted mid-sweep: immediate return to reset values; no done pulse.
- err_count cannot exceed 8, so it never wraps.
- idx does not wrap: vector 7 always ends the sweep.

Optional Feature:
- Macro: TRUTH_SWEEP_SYNC_EN.
- Defined:
  - Input a passes through a 2-flop synchronizer (reset to 0) before sampling.
  - APPLY lasts SETTLE_CYCLES+2 cycles per vector, so the per-vector window is SETTLE_CYCLES+3 cycles.
  - Sweep latency becomes 8*(SETTLE_CYCLES+3).
- Undefined: a is sampled directly; timing as in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release rst, hold start=0 for 10 cycles -> outputs stay 0, busy=0.
- Golden sweep: evaluator connected, defaults, pulse start -> {x,y,z} steps 000..111, each held 3 cycles; done at edge 24; table_out=8'h26, err_count=0, fail_idx=0, pass=1.
- Stuck-at-0 fault: tie a=0 -> table_out=8'h00, err_count=3, fail_idx=1, pass=0, done still at edge 24.
- Start while busy: extra start pulses at cycles 5 and 12 -> single done at edge 24, no restart; held-high start re-triggers only after returning to IDLE.
- Abort mid-sweep: abort at cycle 10 (vector 3) -> IDLE next edge; xyz=000; no done; pass=0; table_out[2:0]=3'b110. A following start runs a full clean sweep -> pass=1.
- With TRUTH_SWEEP_SYNC_EN, SETTLE_CYCLES=1, golden evaluator -> each vector held 4 cycles; done at edge 32; table_out=8'h26, pass=1.

Source files
------------

// File: rtl/truth_sweep_ctrl.sv
// Truth-table sweep sequencer for the 3-input X/Y/Z -> A evaluator.
// Optional TRUTH_SWEEP_SYNC_EN adds a 2-flop synchronizer on a_i and stretches APPLY by 2 cycles.
module truth_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h26
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       a_i,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [7:0] table_out_o,
  output logic [3:0] err_count_o,
  output logic [2:0] fail_idx_o
);

  typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

`ifdef TRUTH_SWEEP_SYNC_EN
  localparam logic [4:0] ApplyLast = 5'(SETTLE_CYCLES + 1);
`else
  localparam logic [4:0] ApplyLast = 5'(SETTLE_CYCLES - 1);
`endif

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] table_q, table_d;
  logic [3:0] err_q, err_d;
  logic [2:0] fidx_q, fidx_d;
  logic       pass_q, pass_d;
  logic       a_smp;

`ifdef TRUTH_SWEEP_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], a_i};
    end
  end

  assign a_smp = sync_q[1];
`else
  assign a_smp = a_i;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StApply;
          vec_d   = 3'd0;
          idx_d   = 3'd0;
          cnt_d   = 5'd0;
          table_d = 8'h00;
          err_d   = 4'd0;
          fidx_d  = 3'd0;
          pass_d  = 1'b0;
        end
      end
      StApply: begin
        if (abort_i) begin
          state_d = StIdle;
          vec_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == ApplyLast) begin
            state_d = StSample;
          end
        end
      end
      StSample: begin
        if (abort_i) begin
          state_d = StIdle;
          vec_d   = 3'd0;
        end else begin
          table_d[idx_q] = a_smp;
          if (a_smp != EXPECTED[idx_q]) begin
            err_d = err_q + 4'd1;
            // An empty error count marks the first mismatch of this sweep.
            if (err_q == 4'd0) begin
              fidx_d = idx_q;
            end
          end
          if (idx_q != 3'd7) begin
            state_d = StApply;
            idx_d   = idx_q + 3'd1;
            vec_d   = idx_q + 3'd1;
            cnt_d   = 5'd0;
          end else begin
            state_d = StDone;
            vec_d   = 3'd0;
            pass_d  = (err_d == 4'd0);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 5'd0;
      table_q <= 8'h00;
      err_q   <= 4'd0;
      fidx_q  <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      pass_q  <= pass_d;
    end
  end

  assign {x_o, y_o, z_o} = vec_q;
  assign busy_o          = (state_q == StApply) || (state_q == StSample);
  assign done_o          = (state_q == StDone);
  assign pass_o          = pass_q;
  assign table_out_o     = table_q;
  assign err_count_o     = err_q;
  assign fail_idx_o      = fidx_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed self-checking bench for truth_sweep_ctrl with a behavioural X/Y/Z -> A evaluator.
module tb_truth_sweep_ctrl;

`ifdef TRUTH_SWEEP_SYNC_EN
  localparam int S = 1;
  localparam int W = S + 3;
`else
  localparam int S = 2;
  localparam int W = S + 1;
`endif
  localparam int LAT = 8 * W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stuck0 = 1'b0;
  logic       a;
  logic       x, y, z, busy, done, pass;
  logic [7:0] table_out;
  logic [3:0] err_count;
  logic [2:0] fail_idx;

  int tests = 0;
  int fails = 0;
  int d_edge, xyz_err, d_cnt, n_done;

  truth_sweep_ctrl #(.SETTLE_CYCLES(S), .EXPECTED(8'h26)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .a_i         (a),
    .x_o         (x),
    .y_o         (y),
    .z_o         (z),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .table_out_o (table_out),
    .err_count_o (err_count),
    .fail_idx_o  (fail_idx)
  );

  always #5 clk = ~clk;

  // Golden network: A is 1 for {X,Y,Z} = 1, 2, 5 (table 8'h26).
  always_comb begin
    a = ((~x & (y ^ z)) | (x & ~y & z)) & ~stuck0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, busy, done, pass, x, y, z, fail_idx, err_count, table_out};
  endfunction

  // Pulse start before edge 0, then watch edges 0..LAT+5 sampling after each edge.
  task automatic do_sweep(input bit extra, output int done_edge, output int bad_xyz,
                          output int done_n);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_edge = -1;
    bad_xyz = 0;
    done_n = 0;
    for (int n = 0; n < LAT + 6; n++) begin
      if (n < LAT) begin
        if (({x, y, z} != 3'(n / W)) || !busy) bad_xyz++;
      end
      if (done) begin
        done_n++;
        if (done_edge < 0) done_edge = n;
      end
      start = extra && (n == 4 || n == 11);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset held from time 0; outputs must already be clear with no clock edge.
    #2;
    check_eq("reset_outs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (all_outs() != 32'd0) n_done++;
    end
    check_eq("idle_quiet", 32'(n_done), 32'd0);

    // Golden sweep
    do_sweep(1'b0, d_edge, xyz_err, d_cnt);
    check_eq("gold_done_edge", 32'(d_edge), 32'(LAT));
    check_eq("gold_done_cnt", 32'(d_cnt), 32'd1);
    check_eq("gold_xyz_seq", 32'(xyz_err), 32'd0);
    check_eq("gold_table", 32'(table_out), 32'h26);
    check_eq("gold_err", 32'(err_count), 32'd0);
    check_eq("gold_fidx", 32'(fail_idx), 32'd0);
    check_eq("gold_pass", 32'(pass), 32'd1);
    check_eq("gold_xyz_end", 32'({x, y, z}), 32'd0);

    // Stuck-at-0 evaluator
    stuck0 = 1'b1;
    do_sweep(1'b0, d_edge, xyz_err, d_cnt);
    check_eq("stuck_done_edge", 32'(d_edge), 32'(LAT));
    check_eq("stuck_table", 32'(table_out), 32'h00);
    check_eq("stuck_err", 32'(err_count), 32'd3);
    check_eq("stuck_fidx", 32'(fail_idx), 32'd1);
    check_eq("stuck_pass", 32'(pass), 32'd0);
    stuck0 = 1'b0;

    // Extra start pulses at edges 5 and 12 are ignored
    do_sweep(1'b1, d_edge, xyz_err, d_cnt);
    check_eq("busy_start_edge", 32'(d_edge), 32'(LAT));
    check_eq("busy_start_cnt", 32'(d_cnt), 32'd1);
    check_eq("busy_start_xyz", 32'(xyz_err), 32'd0);

    // Held-high start: done at LAT, IDLE after LAT+1, re-armed after LAT+2
    @(negedge clk);
    start = 1'b1;
    d_edge = -1;
    for (int n = 0; n <= LAT + 2; n++) begin
      @(negedge clk);
      if (done && d_edge < 0) d_edge = n;
      if (n == LAT + 1) check_eq("held_idle_gap", 32'(busy), 32'd0);
      if (n == LAT + 2) check_eq("held_retrigger", 32'(busy), 32'd1);
    end
    check_eq("held_done_edge", 32'(d_edge), 32'(LAT));
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("held_abort_idle", 32'(busy), 32'd0);

    // Abort during vector 3's APPLY phase
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 3 * W; n++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_xyz", 32'({x, y, z}), 32'd0);
    check_eq("abort_pass", 32'(pass), 32'd0);
    check_eq("abort_table_lo", 32'(table_out[2:0]), 32'b110);
    n_done = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check_eq("abort_no_done", 32'(n_done), 32'd0);
    do_sweep(1'b0, d_edge, xyz_err, d_cnt);
    check_eq("after_abort_pass", 32'(pass), 32'd1);
    check_eq("after_abort_table", 32'(table_out), 32'h26);

    // start and abort together in IDLE: start wins, cancel one cycle later
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("both_start_wins", 32'(busy), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    check_eq("both_cancel", 32'(busy), 32'd0);

    // Asynchronous reset mid-sweep
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midsweep_reset", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check_eq("reset_no_done", 32'(n_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
